mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Memory-side responder for the byte-wide CPU memory bus driven by the memory controller (address, write strobe, write byte in; read byte out).
- Services byte RAM and a small host-I/O window selected by mem_a[17:16]==2'b11: TX byte FIFO, RX holding byte, status, halt.
- Sits between the controller's bus pins and the external RAM/UART side; it is also the simulation RAM model for the bench.

Parameters:
MEM_AW, 17, RAM byte-address width; RAM depth 2**MEM_AW bytes.
TXQ_DEPTH, 8, TX FIFO depth in bytes; power of two, at least 2.
TXQ_AW, 3, log2(TXQ_DEPTH).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous assert, active-low (0 = reset).
mem_a  in  32  byte address from the controller.
mem_wr  in  1  1 = write this cycle, 0 = read.
mem_dout  in  8  write byte from the controller.
mem_din  out  8  read byte to the controller, registered.
tx_data  out  8  head byte of the TX FIFO.
tx_valid  out  1  TX FIFO not empty.
tx_ready  in  1  consumer accepts tx_data when tx_valid && tx_ready.
rx_data  in  8  incoming host byte.
rx_valid  in  1  incoming byte offered.
rx_ready  out  1  holding register empty; byte taken when rx_valid && rx_ready.
halt  out  1  sticky halt request.

Behaviour:
- Reset (rst=0, async) sets: mem_din=0, TX FIFO empty (tx_valid=0, pointers and count 0), rx hold empty (rx_ready=1), overflow flag=0, halt=0. RAM contents are not reset.
- Decode: io_sel = (mem_a[17:16]==2'b11). Otherwise the access is RAM at index mem_a[MEM_AW-1:0]; upper bits are ignored.
- RAM write: when mem_wr=1 and !io_sel, ram[idx] <= mem_dout at the edge.
- RAM read: when mem_wr=0 and !io_sel, mem_din <= ram[idx] at the edge.
  - Latency is exactly 1 cycle: an address presented in cycle k yields data on mem_din during cycle k+1.
  - Back-to-back reads of arbitrary addresses give one byte per cycle.
- Write cycles to any target leave mem_din unchanged.
- I/O map, offset mem_a[2:0] with io_sel=1:
  - Write 0: push mem_dout into the TX FIFO. If the FIFO is full, the byte is dropped and overflow is set (sticky until reset).
  - Write 4: halt <= 1 (sticky until reset).
  - Read 0: mem_din <= rx hold byte if full, else 8'h00. If full, the hold is popped (emptied) at that edge.
  - Read 4: mem_din <= {5'b0, overflow, rx_full, tx_full}.
  - Other offsets: reads return 8'h00; writes are ignored.
- TX FIFO:
  - tx_data = mem[rd_ptr]; tx_valid = (count != 0).
  - Pointers wrap modulo TXQ_DEPTH; count is TXQ_AW+1 bits wide.
  - Push and pop in the same cycle with count=DEPTH: the pop occurs and the push is accepted (no overflow). Count is unchanged.
  - Push and pop in the same cycle with count=0: no pop; the push is accepted; count becomes 1.
- RX hold:
  - rx_ready = !rx_full.
  - On rx_valid && rx_ready, capture rx_data and set rx_full.
  - An I/O read 0 pop and a new capture in the same cycle cannot occur, since rx_ready=0 while full. rx_ready rises the cycle after the pop.
- Reset mid-operation: pending FIFO data and the rx byte are discarded; in-flight reads are lost; mem_din returns to 0.

Decomposition:
- Shared package/defines: IO tag 2'b11, I/O offsets (IO_DATA=0, IO_STAT=4), status bit positions, Read/Write encodings already used by the controller.
- One sub-module: byte_fifo. Synchronous FIFO with push, pop, full, empty, count, parameterised by depth; instantiated for TX.

Test Plan:
- RAM write then read: write 8'hA5 @0x00010, 8'h3C @0x00011; read 0x00010, 0x00011 back-to-back -> mem_din = A5 in the cycle after the first address, 3C in the next.
- TX path: write 8'h48 and 8'h69 to 0x30000, tx_ready=0 -> tx_valid=1, tx_data=48. Raise tx_ready for 2 cycles -> 48 then 69 are consumed, tx_valid=0.
- TX overflow: tx_ready=0; 9 writes to 0x30000 -> status read @0x30004 returns 8'h05 (overflow, tx_full); the 9th byte is absent from drained output.
- RX path: rx_data=8'h7A, rx_valid=1 for 1 cycle -> rx_ready=0. Read 0x30000 -> mem_din=7A, then rx_ready=1; a second read returns 00.
- Halt and async reset: write 0x30004 -> halt=1. Drop rst to 0 mid-cycle -> halt, tx_valid and mem_din go to 0 immediately, rx_ready=1.
- Address aliasing: write 8'h11 @0x00005 with mem_a[31:18]=all-ones -> a read of 0x00005 returns 11, and I/O state is unchanged.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory/host-I/O responder: bus encodings, I/O map, status layout.
package mem_io_responder_pkg;

  typedef enum logic {
    BUS_RD = 1'b0,
    BUS_WR = 1'b1
  } bus_op_e;

  localparam logic [1:0] IO_TAG  = 2'b11;
  localparam logic [2:0] IO_DATA = 3'd0;
  localparam logic [2:0] IO_STAT = 3'd4;

  localparam int STAT_TX_FULL = 0;
  localparam int STAT_RX_FULL = 1;
  localparam int STAT_OVF     = 2;

  typedef struct packed {
    logic ovf;
    logic rx_full;
    logic tx_full;
  } io_status_t;

  function automatic logic [7:0] status_byte(input io_status_t s);
    logic [7:0] b;
    b               = '0;
    b[STAT_TX_FULL] = s.tx_full;
    b[STAT_RX_FULL] = s.rx_full;
    b[STAT_OVF]     = s.ovf;
    return b;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is accepted only when a pop frees a slot
// in the same cycle, otherwise it is dropped and flagged on drop_o.
module mem_io_responder_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [7:0]    push_dat_i,
  input  logic          pop_i,
  output logic [7:0]    head_dat_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          drop_o
);

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == FULL_CNT);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  // A pop always frees the head slot first, so a simultaneous push at full still fits.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && !push_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop_ok) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide memory bus responder: RAM plus a host-I/O window (TX FIFO, RX hold, status, halt).
// Reads return on mem_din one cycle after the address; writes never disturb mem_din.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int MEM_AW    = 17,
  parameter int TXQ_DEPTH = 8,
  parameter int TXQ_AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halt
);

  logic [7:0]        ram_q [2**MEM_AW];
  logic [MEM_AW-1:0] ram_idx;
  bus_op_e           bus_op;
  logic              io_sel;
  logic [2:0]        io_off;

  logic [7:0] mem_din_q, mem_din_d;
  logic       rx_full_q, rx_full_d;
  logic [7:0] rx_dat_q, rx_dat_d;
  logic       ovf_q, ovf_d;
  logic       halt_q, halt_d;

  logic        tx_push, tx_pop, tx_full, tx_empty, tx_drop;
  logic        rx_take, rx_pop, ram_wr, halt_set;
  logic [TXQ_AW:0] unused_tx_count;
  logic        unused_addr_bits;
  io_status_t  status;

  assign bus_op  = bus_op_e'(mem_wr);
  assign io_sel  = (mem_a[17:16] == IO_TAG);
  assign io_off  = mem_a[2:0];
  assign ram_idx = mem_a[MEM_AW-1:0];
  assign unused_addr_bits = ^mem_a;

  assign ram_wr   = (bus_op == BUS_WR) && !io_sel;
  assign tx_push  = (bus_op == BUS_WR) && io_sel && (io_off == IO_DATA);
  assign halt_set = (bus_op == BUS_WR) && io_sel && (io_off == IO_STAT);
  assign rx_pop   = (bus_op == BUS_RD) && io_sel && (io_off == IO_DATA) && rx_full_q;
  assign rx_take  = rx_valid && !rx_full_q;
  assign tx_pop   = tx_valid && tx_ready;

  assign status = '{ovf: ovf_q, rx_full: rx_full_q, tx_full: tx_full};

  mem_io_responder_byte_fifo #(
    .DEPTH (TXQ_DEPTH),
    .AW    (TXQ_AW)
  ) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (tx_push),
    .push_dat_i (mem_dout),
    .pop_i      (tx_pop),
    .head_dat_o (tx_data),
    .full_o     (tx_full),
    .empty_o    (tx_empty),
    .count_o    (unused_tx_count),
    .drop_o     (tx_drop)
  );

  always_comb begin
    mem_din_d = mem_din_q;
    if (bus_op == BUS_RD) begin
      if (!io_sel) begin
        mem_din_d = ram_q[ram_idx];
      end else begin
        case (io_off)
          IO_DATA: mem_din_d = rx_full_q ? rx_dat_q : 8'h00;
          IO_STAT: mem_din_d = status_byte(status);
          default: mem_din_d = 8'h00;
        endcase
      end
    end
  end

  // rx_take and rx_pop are mutually exclusive: one needs the hold empty, the other full.
  always_comb begin
    rx_full_d = rx_full_q;
    rx_dat_d  = rx_dat_q;
    if (rx_pop) begin
      rx_full_d = 1'b0;
    end else if (rx_take) begin
      rx_full_d = 1'b1;
      rx_dat_d  = rx_data;
    end
  end

  assign ovf_d  = ovf_q || tx_drop;
  assign halt_d = halt_q || halt_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_din_q <= 8'h00;
      rx_full_q <= 1'b0;
      rx_dat_q  <= 8'h00;
      ovf_q     <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      mem_din_q <= mem_din_d;
      rx_full_q <= rx_full_d;
      rx_dat_q  <= rx_dat_d;
      ovf_q     <= ovf_d;
      halt_q    <= halt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) ram_q[ram_idx] <= mem_dout;
  end

  assign mem_din  = mem_din_q;
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full_q;
  assign halt     = halt_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, TX/RX paths, overflow, halt, reset, aliasing.
module tb_mem_io_responder;

  logic        clk;
  logic        rst;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        halt;

  int checks = 0;
  int errors = 0;

  mem_io_responder dut (
    .clk      (clk),
    .rst      (rst),
    .mem_a    (mem_a),
    .mem_wr   (mem_wr),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .halt     (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
    mem_a    = a;
    mem_wr   = 1'b1;
    mem_dout = d;
    tick();
  endtask

  task automatic bus_rd(input logic [31:0] a);
    mem_a  = a;
    mem_wr = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] drain_exp [8];

    rst      = 1'b0;
    mem_a    = 32'h0000_0010;
    mem_wr   = 1'b1;
    mem_dout = 8'hA5;
    tx_ready = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tick();
    tick();
    check("rst_mem_din", {24'h0, mem_din}, 32'h00);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("rst_halt", {31'h0, halt}, 32'h0);

    // RAM write, then back-to-back reads
    rst = 1'b1;
    bus_wr(32'h0000_0010, 8'hA5);
    bus_wr(32'h0000_0011, 8'h3C);
    check("wr_keeps_mem_din", {24'h0, mem_din}, 32'h00);
    bus_rd(32'h0000_0010);
    check("ram_rd0", {24'h0, mem_din}, 32'hA5);
    bus_rd(32'h0000_0011);
    check("ram_rd1", {24'h0, mem_din}, 32'h3C);

    // Upper address bits ignored
    bus_wr(32'hFFFC_0005, 8'h11);
    check("alias_wr_keeps_din", {24'h0, mem_din}, 32'h3C);
    bus_rd(32'h0000_0005);
    check("alias_rd", {24'h0, mem_din}, 32'h11);
    check("alias_tx_idle", {31'h0, tx_valid}, 32'h0);
    check("alias_no_halt", {31'h0, halt}, 32'h0);

    // TX path
    bus_wr(32'h0003_0000, 8'h48);
    bus_wr(32'h0003_0000, 8'h69);
    mem_a  = 32'h0000_0010;
    mem_wr = 1'b0;
    check("tx_valid_2", {31'h0, tx_valid}, 32'h1);
    check("tx_head_48", {24'h0, tx_data}, 32'h48);
    tx_ready = 1'b1;
    tick();
    check("tx_head_69", {24'h0, tx_data}, 32'h69);
    check("tx_valid_1", {31'h0, tx_valid}, 32'h1);
    tick();
    check("tx_drained", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // TX overflow
    for (int i = 1; i <= 8; i++) bus_wr(32'h0003_0000, 8'(i));
    bus_rd(32'h0003_0004);
    check("stat_full", {24'h0, mem_din}, 32'h01);
    bus_wr(32'h0003_0000, 8'h09);
    bus_rd(32'h0003_0004);
    check("stat_ovf_full", {24'h0, mem_din}, 32'h05);
    mem_a    = 32'h0000_0010;
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("ovf_drain_vld", {31'h0, tx_valid}, 32'h1);
      check("ovf_drain_dat", {24'h0, tx_data}, 32'(i));
      tick();
    end
    check("ovf_9th_absent", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // RX path
    rx_data  = 8'h7A;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("rx_ready_low", {31'h0, rx_ready}, 32'h0);
    bus_rd(32'h0003_0004);
    check("stat_ovf_rx", {24'h0, mem_din}, 32'h06);
    bus_rd(32'h0003_0000);
    check("rx_rd", {24'h0, mem_din}, 32'h7A);
    check("rx_ready_back", {31'h0, rx_ready}, 32'h1);
    bus_rd(32'h0003_0000);
    check("rx_rd_empty", {24'h0, mem_din}, 32'h00);

    // Halt, then asynchronous reset mid-cycle
    bus_wr(32'h0003_0000, 8'h55);
    bus_wr(32'h0003_0004, 8'h00);
    check("halt_set", {31'h0, halt}, 32'h1);
    rx_data  = 8'h33;
    rx_valid = 1'b1;
    bus_rd(32'h0000_0010);
    rx_valid = 1'b0;
    check("pre_rst_din", {24'h0, mem_din}, 32'hA5);
    check("pre_rst_tx", {31'h0, tx_valid}, 32'h1);
    check("pre_rst_rx", {31'h0, rx_ready}, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_halt", {31'h0, halt}, 32'h0);
    check("arst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("arst_mem_din", {24'h0, mem_din}, 32'h00);
    check("arst_rx_ready", {31'h0, rx_ready}, 32'h1);
    tick();
    rst = 1'b1;
    bus_rd(32'h0000_0010);
    check("ram_survives_rst", {24'h0, mem_din}, 32'hA5);
    bus_rd(32'h0003_0004);
    check("stat_after_rst", {24'h0, mem_din}, 32'h00);

    // Push and pop together at full: accepted, no overflow
    for (int i = 0; i < 8; i++) bus_wr(32'h0003_0000, 8'hB0 + 8'(i));
    tx_ready = 1'b1;
    bus_wr(32'h0003_0000, 8'hAA);
    tx_ready = 1'b0;
    bus_rd(32'h0003_0004);
    check("stat_full_pushpop", {24'h0, mem_din}, 32'h01);
    for (int i = 0; i < 7; i++) drain_exp[i] = 8'hB1 + 8'(i);
    drain_exp[7] = 8'hAA;
    mem_a    = 32'h0000_0010;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("pp_drain_dat", {24'h0, tx_data}, {24'h0, drain_exp[i]});
      tick();
    end
    check("pp_drained", {31'h0, tx_valid}, 32'h0);

    // Push with pop requested while empty: push lands, nothing popped
    bus_wr(32'h0003_0000, 8'hC5);
    check("empty_pp_vld", {31'h0, tx_valid}, 32'h1);
    check("empty_pp_dat", {24'h0, tx_data}, 32'hC5);
    bus_rd(32'h0000_0010);
    check("empty_pp_popped", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
